// File: rtl/sdram_initiator.sv
// SDRAM command initiator: takes one host burst request at a time, sequences
// ACTIVATE / READ|WRITE / PRECHARGE with register-file programmed gaps, streams
// write data out and captures read data back. All outputs are registered.
//
// state  | meaning
// IDLE   | waiting for a host request, req_ready high
// ACT    | ACTIVATE on the strobes
// RCD    | NOP gap of tcas cycles before the column command
// CMD    | READ or WRITE on the strobes (first write beat also driven here)
// WBURST | remaining write beats
// RLAT   | waiting out read latency before the first sample
// RBURST | sampling DataIn, one beat per cycle
// RECOV  | NOP gap of twait cycles after the last beat
// PRE    | PRECHARGE on the strobes
// PWAIT  | NOP gap of tpre cycles before returning to IDLE
module sdram_initiator (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] wdata_i,
    output logic        wdata_pop_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        done_o,
    output logic        CS_o,
    output logic        RAS_o,
    output logic        CAS_o,
    output logic        WE_o,
    output logic [31:0] AddrOut_o,
    output logic [1:0]  Size_o,
    output logic [31:0] DataOut_o,
    input  logic [31:0] DataIn_i,
    input  logic [7:0]  tburst_i,
    input  logic [3:0]  tlat_i,
    input  logic [7:0]  tcas_i,
    input  logic [7:0]  twait_i,
    input  logic [7:0]  tpre_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_RCD, S_CMD, S_WBURST,
        S_RLAT, S_RBURST, S_RECOV, S_PRE, S_PWAIT
    } state_t;

    localparam logic [3:0] CMD_NOP   = 4'b1111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [7:0]  tburst_q, tburst_d;
    logic [3:0]  tlat_q, tlat_d;
    logic [7:0]  tcas_q, tcas_d;
    logic [7:0]  twait_q, twait_d;
    logic [7:0]  tpre_q, tpre_d;

    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] addr_out_q, addr_out_d;
    logic [1:0]  size_out_q, size_out_d;
    logic [31:0] data_out_q, data_out_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        done_q, done_d;
    logic        req_ready_q, req_ready_d;
    logic        wdata_pop_q, wdata_pop_d;

    logic        accept;
    state_t      post_burst_state;
    logic [7:0]  post_burst_cnt;

    assign accept           = req_ready_q & req_valid_i;
    assign post_burst_state = (twait_q == 8'd0) ? S_PRE : S_RECOV;
    assign post_burst_cnt   = twait_q - 8'd1;

    // State, gap counter and latched request/timing registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            size_q   <= 2'd0;
            tburst_q <= 8'd1;
            tlat_q   <= 4'd1;
            tcas_q   <= 8'd0;
            twait_q  <= 8'd0;
            tpre_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            tburst_q <= tburst_d;
            tlat_q   <= tlat_d;
            tcas_q   <= tcas_d;
            twait_q  <= twait_d;
            tpre_q   <= tpre_d;
        end
    end

    // Next state, counter reloads and request capture on accept
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        size_d   = size_q;
        tburst_d = tburst_q;
        tlat_d   = tlat_q;
        tcas_d   = tcas_q;
        twait_d  = twait_q;
        tpre_d   = tpre_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_ACT;
                    we_d     = req_we_i;
                    addr_d   = req_addr_i;
                    size_d   = req_size_i;
                    tburst_d = (tburst_i == 8'd0) ? 8'd1 : tburst_i;
                    tlat_d   = (tlat_i == 4'd0) ? 4'd1 : tlat_i;
                    tcas_d   = tcas_i;
                    twait_d  = twait_i;
                    tpre_d   = tpre_i;
                end
            end
            S_ACT: begin
                if (tcas_q == 8'd0) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_RCD;
                    cnt_d   = tcas_q - 8'd1;
                end
            end
            S_RCD: begin
                if (cnt_q == 8'd0) state_d = S_CMD;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_CMD: begin
                if (we_q) begin
                    if (tburst_q > 8'd1) begin
                        state_d = S_WBURST;
                        cnt_d   = tburst_q - 8'd2;
                    end else begin
                        state_d = post_burst_state;
                        cnt_d   = post_burst_cnt;
                    end
                end else if (tlat_q > 4'd1) begin
                    state_d = S_RLAT;
                    cnt_d   = {4'd0, tlat_q} - 8'd2;
                end else begin
                    state_d = S_RBURST;
                    cnt_d   = tburst_q - 8'd1;
                end
            end
            S_WBURST, S_RBURST: begin
                if (cnt_q == 8'd0) begin
                    state_d = post_burst_state;
                    cnt_d   = post_burst_cnt;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RLAT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_RBURST;
                    cnt_d   = tburst_q - 8'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RECOV: begin
                if (cnt_q == 8'd0) state_d = S_PRE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_PRE: begin
                if (tpre_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PWAIT;
                    cnt_d   = tpre_q - 8'd1;
                end
            end
            S_PWAIT: begin
                if (cnt_q == 8'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered
    always_comb begin
        cmd_d = CMD_NOP;
        case (state_d)
            S_ACT:   cmd_d = CMD_ACT;
            S_CMD:   cmd_d = we_d ? CMD_WRITE : CMD_READ;
            S_PRE:   cmd_d = CMD_PRE;
            default: cmd_d = CMD_NOP;
        endcase
        addr_out_d  = (state_d == S_ACT || state_d == S_CMD) ? addr_d : addr_out_q;
        size_out_d  = (state_d == S_ACT) ? size_d : size_out_q;
        req_ready_d = (state_d == S_IDLE);
        done_d      = (state_d == S_IDLE) && (state_q != S_IDLE);
        // Pop one cycle ahead of every beat, so the beat cycle shows registered wdata
        wdata_pop_d = we_d && (((state_d == S_ACT) && (tcas_d == 8'd0)) ||
                               ((state_d == S_RCD) && (cnt_d == 8'd0)) ||
                               ((state_d == S_CMD) && (tburst_d > 8'd1)) ||
                               ((state_d == S_WBURST) && (cnt_d != 8'd0)));
        data_out_d    = wdata_pop_q ? wdata_i : 32'd0;
        rdata_valid_d = (state_q == S_RBURST);
        rdata_d       = (state_q == S_RBURST) ? DataIn_i : rdata_q;
    end

    // Registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cmd_q         <= CMD_NOP;
            addr_out_q    <= 32'd0;
            size_out_q    <= 2'd0;
            data_out_q    <= 32'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            req_ready_q   <= 1'b1;
            wdata_pop_q   <= 1'b0;
        end else begin
            cmd_q         <= cmd_d;
            addr_out_q    <= addr_out_d;
            size_out_q    <= size_out_d;
            data_out_q    <= data_out_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            req_ready_q   <= req_ready_d;
            wdata_pop_q   <= wdata_pop_d;
        end
    end

    assign {CS_o, RAS_o, CAS_o, WE_o} = cmd_q;
    assign AddrOut_o     = addr_out_q;
    assign Size_o        = size_out_q;
    assign DataOut_o     = data_out_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign done_o        = done_q;
    assign req_ready_o   = req_ready_q;
    assign wdata_pop_o   = wdata_pop_q;

endmodule

// File: doc/sdram_initiator.md
# sdram_initiator

Command-issuing end of the SDRAM bank interface: accepts one host read/write burst request at a time and drives the active-low CS/RAS/CAS/WE command strobes, address, size and write data towards an SDRAM bank, capturing returned read data. Sits between the bus-interface logic and the SDRAM bank. Uses the same register-file timing inputs as the bank, so both ends agree on burst length and latencies.

## Interface
- No parameters; all timing comes from register-file inputs.
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  host request present
- req_ready  out  1  initiator idle, can accept request
- req_we  in  1  1 = write burst, 0 = read burst
- req_addr  in  32  burst start address
- req_size  in  2  data packet size, forwarded on Size
- wdata  in  32  host write data
- wdata_pop  out  1  wdata consumed at this edge
- rdata  out  32  captured read beat
- rdata_valid  out  1  rdata holds a new beat
- done  out  1  one-cycle pulse: burst and precharge complete
- CS, RAS, CAS, WE  out  1 each  active-low command strobes
- AddrOut  out  32  command address
- Size  out  2  size of current burst
- DataOut  out  32  write data towards bank
- DataIn  in  32  read data from bank
- tburst  in  8  beats per burst; 0 treated as 1
- tlat  in  4  read latency; 0 treated as 1
- tcas  in  8  NOP cycles between ACTIVATE and READ/WRITE
- twait  in  8  NOP cycles between last beat and PRECHARGE
- tpre  in  8  NOP cycles after PRECHARGE before idle

## Operation
- Commands {CS,RAS,CAS,WE}: NOP 1111; ACTIVATE 0011; READ 0101; WRITE 0100; PRECHARGE 0010. Each non-NOP command lasts exactly one cycle; all other cycles are NOP.
- All outputs registered. Reset values: strobes 1111, req_ready 1, wdata_pop 0, rdata_valid 0, done 0, AddrOut/Size/DataOut/rdata 0.
- Accept at edge with req_valid && req_ready. Latch we/addr/size and timing inputs; req_ready drops until IDLE is re-entered. req_valid is ignored while busy.
- FSM: IDLE -> ACT -> RCD (tcas cycles, skipped if 0) -> CMD -> WBURST or RLAT/RBURST -> RECOV (twait cycles, skipped if 0) -> PRE -> PWAIT (tpre cycles, skipped if 0) -> IDLE.
- AddrOut = latched address during ACTIVATE and READ/WRITE; held otherwise. The bank increments the column internally, so one READ/WRITE command covers the whole burst.
- Write: wdata_pop is high in the cycle before each of the tburst beats. Captured wdata appears on DataOut in the following cycle. DataOut returns to 0 after the last beat.
- Read: DataIn sampled on tburst consecutive edges. Each sample is registered into rdata with rdata_valid high for that cycle.
- Counters are 8-bit down-counters loaded from the latched values; no wrap-around is possible.
- Reset mid-burst: FSM returns to IDLE at that edge. All outputs take reset values next cycle. No PRECHARGE is issued and no done pulse.

## Timing
- Accept at end of cycle A. ACTIVATE in cycle A+1. Command cycle C = A+2+tcas.
- Write beats driven in cycles C .. C+tburst-1. Last-beat cycle L = C+tburst-1. wdata_pop high in cycles C-1 .. C+tburst-2.
- Read: DataIn sampled at end of cycles C+tlat .. C+tlat+tburst-1. rdata_valid high in cycles C+tlat+1 .. C+tlat+tburst. L = C+tlat+tburst-1.
- PRECHARGE in cycle L+1+twait. done and req_ready high in cycle L+2+twait+tpre.
- A new request may be accepted in the same cycle done is high.

## Test plan
- Write, tcas=2, tburst=4, twait=1, tpre=2, addr 0x1234, accept cycle 0 -> ACT cycle 1 with AddrOut 0x1234; WRITE cycle 4; DataOut beats D0..D3 in cycles 4-7; PRE cycle 9; done/req_ready cycle 12.
- Read, same settings, tlat=3, bank returns 0xA0..0xA3 -> READ cycle 4; rdata 0xA0..0xA3 with rdata_valid in cycles 8-11; PRE cycle 12; done cycle 15.
- Minimum settings, tcas=twait=tpre=0, tlat=0, tburst=0, read -> ACT 1, READ 2, one beat sampled end of cycle 3, PRE 4, done 5.
- reset asserted during write beat 2 (tburst=8) -> next cycle strobes 1111, DataOut 0, req_ready 1; no PRECHARGE, no done.
- req_valid held high through a burst with changing req_addr -> only the first address is used; second request accepted in the done cycle, its ACT in the next cycle.
- req_size=2'b10 -> Size=2'b10 from ACT until the next accept. Strobes never show a non-NOP pattern for more than one consecutive cycle.
